exe_seq_ctrl: RTL
=================

EXE_SEQ_CTRL -- requirements
Module: exe_seq_ctrl

Interface
REQ-001 Parameter m, default 4: operand/result width.
REQ-002 Parameter n, default 2: opcode width.
REQ-003 Parameter LAT, default 1: execution-unit latency in clocks; legal range 1..7.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_cmd_valid  input  1  command request from host.
REQ-007 o_cmd_ready  output  1  controller accepts a command this cycle.
REQ-008 i_oper  input  n  command opcode.
REQ-009 i_argA  input  m  command operand A.
REQ-010 i_argB  input  m  command operand B.
REQ-011 o_oper  output  n  opcode driven to execution unit.
REQ-012 o_argA  output  m  operand A driven to execution unit.
REQ-013 o_argB  output  m  operand B driven to execution unit.
REQ-014 i_result  input  m  result returned by execution unit.
REQ-015 i_status  input  2  status returned by execution unit.
REQ-016 o_rsp_valid  output  1  response available to host.
REQ-017 i_rsp_ready  input  1  host accepts response.
REQ-018 o_rsp_result  output  m  captured result.
REQ-019 o_rsp_status  output  2  captured status.
REQ-020 o_cmd_cnt  output  8  completed-command count, wraps at 255->0.
REQ-021 o_flag_cnt  output  8  count of responses with status != 2'b00, saturates at 255.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-023 o_cmd_ready SHALL be 1 only in IDLE; a command is accepted when i_cmd_valid && o_cmd_ready.
REQ-024 On acceptance in cycle T, i_oper/i_argA/i_argB SHALL be registered into o_oper/o_argA/o_argB, and the FSM SHALL enter ISSUE at T+1.
REQ-025 o_oper/o_argA/o_argB SHALL hold stable from T+1 until the next accepted command.
REQ-026 ISSUE SHALL last exactly one cycle, then enter WAIT with the latency counter loaded to LAT-1.
REQ-027 WAIT SHALL decrement the counter each cycle; on the cycle the counter equals 0, i_result/i_status SHALL be captured into o_rsp_result/o_rsp_status, and the FSM SHALL enter RESP.
REQ-028 With LAT=1, o_rsp_valid SHALL first assert at T+3.
REQ-029 In RESP, o_rsp_valid=1, and o_rsp_result/o_rsp_status SHALL hold stable until i_rsp_ready=1.
REQ-030 On RESP && i_rsp_ready, the FSM SHALL return to IDLE next cycle, o_cmd_cnt SHALL increment, and o_flag_cnt SHALL increment if o_rsp_status != 2'b00 and is below 255.
REQ-031 i_cmd_valid during ISSUE/WAIT/RESP SHALL be ignored (o_cmd_ready=0); no command buffering.
REQ-032 Maximum throughput SHALL be one command per LAT+3 cycles, with i_rsp_ready held high.
REQ-033 i_rsp_ready outside RESP SHALL have no effect.
REQ-034 Illegal FSM encodings SHALL transition to IDLE.

Reset
REQ-035 i_rst=1 at a rising edge SHALL force IDLE regardless of the current state, including mid-WAIT or mid-RESP; any in-flight response SHALL be discarded.
REQ-036 Reset values: o_rsp_valid=0, o_rsp_result='0, o_rsp_status=2'b00, o_oper/o_argA/o_argB='0, o_cmd_cnt=0, o_flag_cnt=0, latency counter=0.
REQ-037 o_cmd_ready SHALL be 0 while i_rst=1 and 1 in the first cycle after release.

Structure
REQ-038 A shared package exe_pkg SHALL hold the FSM state enum, default widths (m=4, n=2), and status constant STAT_OK=2'b00.
REQ-039 The module SHALL be a single module with no sub-modules; the counters and FSM are inline.

Verification
REQ-040 The bench SHALL use an execution-unit model with latency LAT, result = argA ^ argB, status = oper.
REQ-041 Single command, LAT=1: cmd (oper=2'b00, A=4'h5, B=4'h3) at T -> o_rsp_valid at T+3, result 4'h6, status 00; o_cmd_cnt=1, o_flag_cnt=0.
REQ-042 Backpressure: oper=2'b10, A=4'hF, B=4'h1, i_rsp_ready low for 5 cycles -> result 4'hE and status 10 stable throughout; o_flag_cnt=1 after accept; o_cmd_ready stays 0.
REQ-043 Back-to-back: 4 commands with i_cmd_valid held high and i_rsp_ready high -> acceptances spaced exactly 4 cycles apart; o_cmd_cnt=4.
REQ-044 Reset mid-WAIT with LAT=3: assert i_rst at T+2 -> next cycle IDLE, o_rsp_valid=0, all counters 0, and no response issued.
REQ-045 Counters: 256 commands, each with oper=2'b01 -> o_cmd_cnt wraps to 0, o_flag_cnt saturates at 255.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared types and constants for the execution-unit sequencing controller.
package exe_pkg;

   localparam int unsigned M_DEFAULT = 4;
   localparam int unsigned N_DEFAULT = 2;
   localparam int unsigned STAT_W    = 2;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned LAT_W     = 3;

   localparam logic [STAT_W-1:0] STAT_OK = 2'b00;
   localparam logic [CNT_W-1:0]  CNT_MAX = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_RESP  = 2'b11
   } state_e;

   // Increment that sticks at the counter's maximum value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/exe_seq_ctrl.sv
// Single-command sequencer: accepts a host command, drives it to an execution unit,
// waits LAT clocks for the result and holds the response until the host takes it.
module exe_seq_ctrl
   import exe_pkg::*;
#(
   parameter int unsigned m   = M_DEFAULT,
   parameter int unsigned n   = N_DEFAULT,
   parameter int unsigned LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [n-1:0]      i_oper,
   input  logic [m-1:0]      i_argA,
   input  logic [m-1:0]      i_argB,
   output logic [n-1:0]      o_oper,
   output logic [m-1:0]      o_argA,
   output logic [m-1:0]      o_argB,
   input  logic [m-1:0]      i_result,
   input  logic [STAT_W-1:0] i_status,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [m-1:0]      o_rsp_result,
   output logic [STAT_W-1:0] o_rsp_status,
   output logic [CNT_W-1:0]  o_cmd_cnt,
   output logic [CNT_W-1:0]  o_flag_cnt
);

   state_e           state_q;
   state_e           state_d;
   logic [LAT_W-1:0] lat_cnt_q;
   logic             accept_c;
   logic             issue_c;
   logic             capture_c;
   logic             retire_c;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; unknown encodings fall back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_cmd_valid) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (lat_cnt_q == '0) state_d = ST_RESP;
         ST_RESP:  if (i_rsp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Handshake and datapath strobes; ready is masked while reset is held.
   always_comb begin
      o_cmd_ready = 1'b0;
      accept_c    = 1'b0;
      issue_c     = 1'b0;
      capture_c   = 1'b0;
      retire_c    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_cmd_ready = !i_rst;
            accept_c    = i_cmd_valid && !i_rst;
         end
         ST_ISSUE: issue_c   = 1'b1;
         ST_WAIT:  capture_c = (lat_cnt_q == '0);
         ST_RESP:  retire_c  = i_rsp_ready;
         default: ;
      endcase
   end

   // Command operands held toward the execution unit until the next acceptance.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_oper <= '0;
         o_argA <= '0;
         o_argB <= '0;
      end else if (accept_c) begin
         o_oper <= i_oper;
         o_argA <= i_argA;
         o_argB <= i_argB;
      end
   end

   // Latency counter: loaded in ISSUE, counts down through WAIT.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lat_cnt_q <= '0;
      end else if (issue_c) begin
         lat_cnt_q <= LAT_W'(LAT - 1);
      end else if (state_q == ST_WAIT && lat_cnt_q != '0) begin
         lat_cnt_q <= lat_cnt_q - LAT_W'(1);
      end
   end

   // Response capture and hold until the host accepts it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rsp_valid  <= 1'b0;
         o_rsp_result <= '0;
         o_rsp_status <= STAT_OK;
      end else if (capture_c) begin
         o_rsp_valid  <= 1'b1;
         o_rsp_result <= i_result;
         o_rsp_status <= i_status;
      end else if (retire_c) begin
         o_rsp_valid  <= 1'b0;
      end
   end

   // Completion counters: command count wraps, flagged-status count saturates.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_cmd_cnt  <= '0;
         o_flag_cnt <= '0;
      end else if (retire_c) begin
         o_cmd_cnt <= o_cmd_cnt + CNT_W'(1);
         if (o_rsp_status != STAT_OK) begin
            o_flag_cnt <= sat_inc(o_flag_cnt);
         end
      end
   end

endmodule
